// File: rtl/imm_encoder_if.sv
`default_nettype none
// ============================================================================
// imm_encoder_if : request/result handshake bundle for imm_encoder
// Rev 1.0
// ============================================================================
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [31:0] in_base;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  // slave is the encoder side, master is the loader/consumer side
  modport slave (
    input  in_valid, in_type, in_base, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );

  modport master (
    output in_valid, in_type, in_base, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );
endinterface
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
// imm_encoder : 2-stage RISC-V immediate encoder (range check + bit scatter)
// Rev 1.0
// ============================================================================
module imm_encoder (
  input  wire logic        clk,
  input  wire logic        rstn,
  input  wire logic        clr,
  imm_encoder_if.slave     bus,
  output logic [15:0]      enc_cnt,
  output logic [15:0]      err_cnt
);

  localparam logic [2:0] TYPE_S  = 3'b001;
  localparam logic [2:0] TYPE_I  = 3'b010;
  localparam logic [2:0] TYPE_B  = 3'b011;
  localparam logic [2:0] TYPE_U  = 3'b100;
  localparam logic [2:0] TYPE_J  = 3'b101;
  localparam logic [2:0] TYPE_SH = 3'b110;

  logic        s1_valid;
  logic [2:0]  s1_type;
  logic [31:0] s1_base;
  logic [31:0] s1_imm;
  logic        s1_err;
  logic        s2_valid;
  logic [31:0] s2_instr;
  logic        s2_err;

  logic        in_err;
  logic [31:0] merged;
  logic        s1_adv;
  logic        accept;
  logic        out_xfer;

  assign s1_adv       = !s2_valid || bus.out_ready;
  assign bus.in_ready = !clr && (!s1_valid || s1_adv);
  assign accept       = bus.in_valid && bus.in_ready;
  assign out_xfer     = s2_valid && bus.out_ready;

  assign bus.out_valid = s2_valid;
  assign bus.out_instr = s2_instr;
  assign bus.out_err   = s2_err;

  // Range check happens on the raw request so stage 1 carries a ready-made flag
  always_comb begin
    in_err = 1'b1;
    case (bus.in_type)
      TYPE_I, TYPE_S: in_err = !((&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]));
      TYPE_B:  in_err = !((&bus.in_imm[31:12]) || !(|bus.in_imm[31:12])) || bus.in_imm[0];
      TYPE_J:  in_err = !((&bus.in_imm[31:20]) || !(|bus.in_imm[31:20])) || bus.in_imm[0];
      TYPE_U:  in_err = |bus.in_imm[11:0];
      TYPE_SH: in_err = |bus.in_imm[31:5];
      default: in_err = 1'b1;
    endcase
  end

  // Erroneous requests pass the skeleton through untouched
  always_comb begin
    merged = s1_base;
    if (!s1_err) begin
      case (s1_type)
        TYPE_I:  merged = {s1_imm[11:0], s1_base[19:0]};
        TYPE_S:  merged = {s1_imm[11:5], s1_base[24:12], s1_imm[4:0], s1_base[6:0]};
        TYPE_B:  merged = {s1_imm[12], s1_imm[10:5], s1_base[24:12],
                           s1_imm[4:1], s1_imm[11], s1_base[6:0]};
        TYPE_U:  merged = {s1_imm[31:12], s1_base[11:0]};
        TYPE_J:  merged = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                           s1_base[11:0]};
        TYPE_SH: merged = {s1_base[31:25], s1_imm[4:0], s1_base[19:0]};
        default: merged = s1_base;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_type  <= 3'd0;
      s1_base  <= 32'd0;
      s1_imm   <= 32'd0;
      s1_err   <= 1'b0;
      s2_valid <= 1'b0;
      s2_instr <= 32'd0;
      s2_err   <= 1'b0;
      enc_cnt  <= 16'd0;
      err_cnt  <= 16'd0;
    end else if (clr) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      enc_cnt  <= 16'd0;
      err_cnt  <= 16'd0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_type  <= bus.in_type;
        s1_base  <= bus.in_base;
        s1_imm   <= bus.in_imm;
        s1_err   <= in_err;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_instr <= merged;
          s2_err   <= s1_err;
        end
      end

      if (out_xfer) begin
        enc_cnt <= enc_cnt + 16'd1;
        if (s2_err) begin
          err_cnt <= err_cnt + 16'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
// tb_imm_encoder : directed self-checking bench for imm_encoder
// Rev 1.0
// ============================================================================
module tb_imm_encoder;
  logic        clk = 1'b0;
  logic        rstn;
  logic        clr;
  logic [15:0] enc_cnt;
  logic [15:0] err_cnt;
  int          checks = 0;
  int          errors = 0;

  imm_encoder_if bus();

  imm_encoder dut (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (clr),
    .bus     (bus),
    .enc_cnt (enc_cnt),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  // Drives one request with out_ready=1 and returns what came out and how many
  // edges it took; a timeout leaves instr/err as X and lat negative or huge.
  task automatic run_one(input logic [2:0] t, input logic [31:0] b, input logic [31:0] im,
                         output logic [31:0] instr, output logic err, output int lat);
    bit acc;
    acc   = 1'b0;
    lat   = -1;
    instr = 'x;
    err   = 1'bx;
    bus.out_ready = 1'b1;
    bus.in_type   = t;
    bus.in_base   = b;
    bus.in_imm    = im;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 20 && !acc; c++) begin
      acc = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (acc) begin
      lat = 1;
      for (int c = 0; c < 20; c++) begin
        if (bus.out_valid) begin
          instr = bus.out_instr;
          err   = bus.out_err;
          break;
        end
        @(posedge clk); #1;
        lat++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid_in_reset got %b want 0", bus.out_valid);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    checks++;
    if ({bus.out_valid, bus.out_err, bus.out_instr} !== 34'd0) begin
      errors++; $display("FAIL reset_outputs got v=%b e=%b i=%h want 0", bus.out_valid, bus.out_err, bus.out_instr);
    end
    checks++;
    if (enc_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_counters got %h/%h want 0/0", enc_cnt, err_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_i_type();
    logic [31:0] ins; logic e; int lat;
    run_one(3'b010, 32'h00000013, 32'hFFFFFFFF, ins, e, lat);
    checks++;
    if (ins !== 32'hFFF00013 || e !== 1'b0) begin
      errors++; $display("FAIL i_type got %h err=%b want fff00013 err=0", ins, e);
    end
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL i_type_latency got %0d want 2", lat);
    end
  endtask

  task automatic test_s_b();
    logic [31:0] ins; logic e; int lat;
    run_one(3'b001, 32'h00002023, 32'h00000008, ins, e, lat);
    checks++;
    if (ins !== 32'h00002423 || e !== 1'b0) begin
      errors++; $display("FAIL s_type got %h err=%b want 00002423 err=0", ins, e);
    end
    run_one(3'b011, 32'h00000063, 32'hFFFFFFFC, ins, e, lat);
    checks++;
    if (ins !== 32'hFE000EE3 || e !== 1'b0) begin
      errors++; $display("FAIL b_type got %h err=%b want fe000ee3 err=0", ins, e);
    end
  endtask

  task automatic test_j_u_shamt();
    logic [31:0] ins; logic e; int lat;
    run_one(3'b101, 32'h0000006F, 32'h00000800, ins, e, lat);
    checks++;
    if (ins !== 32'h0010006F || e !== 1'b0) begin
      errors++; $display("FAIL j_type got %h err=%b want 0010006f err=0", ins, e);
    end
    run_one(3'b100, 32'h00000037, 32'h12345000, ins, e, lat);
    checks++;
    if (ins !== 32'h12345037 || e !== 1'b0) begin
      errors++; $display("FAIL u_type got %h err=%b want 12345037 err=0", ins, e);
    end
    run_one(3'b110, 32'h40005013, 32'h00000003, ins, e, lat);
    checks++;
    if (ins !== 32'h40305013 || e !== 1'b0) begin
      errors++; $display("FAIL shamt_type got %h err=%b want 40305013 err=0", ins, e);
    end
  endtask

  task automatic test_errors();
    logic [31:0] ins; logic e; int lat;
    run_one(3'b010, 32'h00000013, 32'd2048, ins, e, lat);
    checks++;
    if (ins !== 32'h00000013 || e !== 1'b1) begin
      errors++; $display("FAIL err_i_range got %h err=%b want 00000013 err=1", ins, e);
    end
    run_one(3'b011, 32'h00000063, 32'd3, ins, e, lat);
    checks++;
    if (ins !== 32'h00000063 || e !== 1'b1) begin
      errors++; $display("FAIL err_b_odd got %h err=%b want 00000063 err=1", ins, e);
    end
    run_one(3'b111, 32'h12345678, 32'd0, ins, e, lat);
    checks++;
    if (ins !== 32'h12345678 || e !== 1'b1) begin
      errors++; $display("FAIL err_bad_type got %h err=%b want 12345678 err=1", ins, e);
    end
    checks++;
    if (err_cnt !== 16'd3 || enc_cnt !== 16'd9) begin
      errors++; $display("FAIL err_counters got enc=%0d err=%0d want enc=9 err=3", enc_cnt, err_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] imms [8];
    logic [31:0] exps [8];
    logic [15:0] pat;
    int  sent, recv, occ;
    bit  in_hs, out_hs, exp_rdy;
    imms = '{32'd1, 32'd2, 32'hFFFFFFFF, 32'd5, 32'hFFFFF800, 32'd2047, 32'd100, 32'd0};
    exps = '{32'h00100013, 32'h00200013, 32'hFFF00013, 32'h00500013,
             32'h80000013, 32'h7FF00013, 32'h06400013, 32'h00000013};
    pat  = 16'b1011_0110_1000_1000;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 200 && recv < 8; cyc++) begin
      bus.out_ready = (cyc < 16) ? pat[cyc] : 1'b1;
      bus.in_type   = 3'b010;
      bus.in_base   = 32'h00000013;
      bus.in_imm    = (sent < 8) ? imms[sent] : 32'd0;
      bus.in_valid  = (sent < 8);
      #1;
      occ     = sent - recv;
      exp_rdy = !(occ == 2 && !bus.out_ready);
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        errors++; $display("FAIL bp_in_ready cyc=%0d got %b want %b", cyc, bus.in_ready, exp_rdy);
      end
      in_hs  = bus.in_valid && bus.in_ready;
      out_hs = bus.out_valid && bus.out_ready;
      if (out_hs) begin
        checks++;
        if (bus.out_instr !== exps[recv] || bus.out_err !== 1'b0) begin
          errors++; $display("FAIL bp_result%0d got %h err=%b want %h err=0", recv, bus.out_instr, bus.out_err, exps[recv]);
        end
      end
      @(posedge clk); #1;
      if (in_hs) sent++;
      if (out_hs) recv++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (recv !== 8) begin
      errors++; $display("FAIL bp_count got %0d results want 8", recv);
    end
    checks++;
    if (enc_cnt !== 16'd8 || err_cnt !== 16'd0) begin
      errors++; $display("FAIL bp_enc_cnt got enc=%0d err=%0d want 8/0", enc_cnt, err_cnt);
    end
  endtask

  task automatic test_clr();
    logic [31:0] ins; logic e; int lat; int pushed;
    bus.out_ready = 1'b0;
    bus.in_type   = 3'b010;
    bus.in_base   = 32'h00000013;
    bus.in_imm    = 32'd7;
    bus.in_valid  = 1'b1;
    pushed = 0;
    for (int c = 0; c < 20 && pushed < 2; c++) begin
      if (bus.in_ready) pushed++;
      @(posedge clk); #1;
    end
    checks++;
    if (pushed !== 2 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL clr_fill got pushed=%0d v=%b rdy=%b want 2/1/0", pushed, bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    clr = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL clr_in_ready got %b want 0", bus.in_ready);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || enc_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      errors++; $display("FAIL clr_flush got v=%b enc=%0d err=%0d want 0/0/0", bus.out_valid, enc_cnt, err_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL clr_no_ghost got v=%b want 0", bus.out_valid);
    end
    run_one(3'b110, 32'h00001013, 32'd31, ins, e, lat);
    checks++;
    if (ins !== 32'h01F01013 || e !== 1'b0 || lat !== 2) begin
      errors++; $display("FAIL clr_after got %h err=%b lat=%0d want 01f01013 err=0 lat=2", ins, e, lat);
    end
    checks++;
    if (enc_cnt !== 16'd1) begin
      errors++; $display("FAIL clr_after_cnt got %0d want 1", enc_cnt);
    end
  endtask

  initial begin
    rstn          = 1'b0;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_type   = 3'd0;
    bus.in_base   = 32'd0;
    bus.in_imm    = 32'd0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_i_type();
    test_s_b();
    test_j_u_shamt();
    test_errors();
    test_backpressure();
    test_clr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
